// File: rtl/regfile_alu.sv
// regfile_alu: 2**WIDTH_SEG x WIDTH_WORD register file (two write, two read ports) feeding a combinational ALU.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_alu #(
    parameter int WIDTH_WORD = 8,
    parameter int WIDTH_SEG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write0,
    input  logic                  write1,
    input  logic [WIDTH_SEG-1:0]  srcreg0,
    input  logic [WIDTH_SEG-1:0]  srcreg1,
    input  logic [WIDTH_WORD-1:0] srcval0,
    input  logic [WIDTH_WORD-1:0] srcval1,
    input  logic [WIDTH_SEG-1:0]  dstreg0,
    input  logic [WIDTH_SEG-1:0]  dstreg1,
    output logic [WIDTH_WORD-1:0] dstval0,
    output logic [WIDTH_WORD-1:0] dstval1,
    input  logic [2:0]            alu_op,
    output logic [WIDTH_WORD-1:0] retval,
    output logic                  carry
);

    localparam int NUM_REGS = 2**WIDTH_SEG;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_EQ   = 3'b101;
    localparam logic [2:0] OP_LT   = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [WIDTH_WORD-1:0] r_regs [NUM_REGS];

    logic [WIDTH_WORD-1:0] w_rd0;
    logic [WIDTH_WORD-1:0] w_rd1;
    logic [WIDTH_WORD:0]   w_sum;
    logic [WIDTH_WORD:0]   w_diff;
    logic [WIDTH_WORD-1:0] w_ret;
    logic                  w_carry;

    // Port 1 is assigned last so it wins when both ports hit the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (write0) r_regs[srcreg0] <= srcval0;
            if (write1) r_regs[srcreg1] <= srcval1;
        end
    end

    always_comb begin
        w_rd0 = r_regs[dstreg0];
        w_rd1 = r_regs[dstreg1];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed in reset so reads stay at zero while writes are ignored.
        if (rst_n) begin
            if (write0 && (srcreg0 == dstreg0)) w_rd0 = srcval0;
            if (write1 && (srcreg1 == dstreg0)) w_rd0 = srcval1;
            if (write0 && (srcreg0 == dstreg1)) w_rd1 = srcval0;
            if (write1 && (srcreg1 == dstreg1)) w_rd1 = srcval1;
        end
`endif
    end

    assign dstval0 = w_rd0;
    assign dstval1 = w_rd1;

    assign w_sum  = {1'b0, w_rd0} + {1'b0, w_rd1};
    assign w_diff = {1'b0, w_rd0} - {1'b0, w_rd1};

    // The extra top bit of the subtraction is the borrow (set exactly when A < B).
    always_comb begin
        w_ret   = '0;
        w_carry = 1'b0;
        case (alu_op)
            OP_ADD: begin
                w_ret   = w_sum[WIDTH_WORD-1:0];
                w_carry = w_sum[WIDTH_WORD];
            end
            OP_SUB: begin
                w_ret   = w_diff[WIDTH_WORD-1:0];
                w_carry = w_diff[WIDTH_WORD];
            end
            OP_AND:  w_ret = w_rd0 & w_rd1;
            OP_OR:   w_ret = w_rd0 | w_rd1;
            OP_NOT:  w_ret = ~w_rd0;
            OP_EQ:   w_ret = {{(WIDTH_WORD-1){1'b0}}, (w_rd0 == w_rd1)};
            OP_LT:   w_ret = {{(WIDTH_WORD-1){1'b0}}, (w_rd0 < w_rd1)};
            OP_PASS: w_ret = w_rd0;
            default: w_ret = w_rd0;
        endcase
    end

    assign retval = w_ret;
    assign carry  = w_carry;

endmodule

// File: tb/tb_regfile_alu.sv
// Self-checking bench for regfile_alu: expectations queued on a scoreboard as stimulus is applied.
// Bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile_alu;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] AND_ = 3'b010;
    localparam logic [2:0] OR_  = 3'b011;
    localparam logic [2:0] NOT_ = 3'b100;
    localparam logic [2:0] EQ   = 3'b101;
    localparam logic [2:0] LT   = 3'b110;
    localparam logic [2:0] PASS = 3'b111;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write0 = 1'b0, write1 = 1'b0;
    logic [3:0] srcreg0 = '0, srcreg1 = '0, dstreg0 = '0, dstreg1 = '0;
    logic [7:0] srcval0 = '0, srcval1 = '0;
    logic [2:0] alu_op = '0;
    logic [7:0] dstval0, dstval1, retval;
    logic       carry;

    always #5 clk = ~clk;

    regfile_alu #(.WIDTH_WORD(8), .WIDTH_SEG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .write0(write0), .write1(write1),
        .srcreg0(srcreg0), .srcreg1(srcreg1),
        .srcval0(srcval0), .srcval1(srcval1),
        .dstreg0(dstreg0), .dstreg1(dstreg1),
        .dstval0(dstval0), .dstval1(dstval1),
        .alu_op(alu_op), .retval(retval), .carry(carry)
    );

    typedef struct {
        string      name;
        logic [24:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic drive(input logic w0, input logic [3:0] a0, input logic [7:0] v0,
                         input logic w1, input logic [3:0] a1, input logic [7:0] v1,
                         input logic [3:0] r0, input logic [3:0] r1, input logic [2:0] op);
        write0 = w0; srcreg0 = a0; srcval0 = v0;
        write1 = w1; srcreg1 = a1; srcval1 = v1;
        dstreg0 = r0; dstreg1 = r1; alu_op = op;
    endtask

    task automatic push_exp(input string name, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] ret, input logic c);
        exp_t e;
        e.name = name;
        e.v = {d0, d1, ret, c};
        sb.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 4'd7, 8'h99, 1'b1, 4'd3, 8'h5A, 4'd7, 4'd3, ADD);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 8'h99, 1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), ADD);
            push_exp($sformatf("reset_low_r%0d", i), 8'h00, 8'h00, 8'h00, 1'b0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dstval0, dstval1, retval, carry} !== e.v) begin
                n_err++;
                $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                         e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
            end
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, ADD);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), ADD);
            push_exp($sformatf("after_reset_r%0d_r%0d", i, 15 - i), 8'h00, 8'h00, 8'h00, 1'b0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dstval0, dstval1, retval, carry} !== e.v) begin
                n_err++;
                $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                         e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_add;
        exp_t e;
        drive(1'b1, 4'd1, 8'd8, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, ADD);
        @(negedge clk);
        drive(1'b1, 4'd3, 8'd5, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, ADD);
        @(negedge clk);
        push_exp("add_r3_r1", 8'd5, 8'd8, 8'd13, 1'b0);
        push_exp("read_r2_sum", 8'd13, 8'd13, 8'd13, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd3, 4'd1, ADD);
        #1;
        e = sb.pop_front();
        n_chk++;
        if ({dstval0, dstval1, retval, carry} !== e.v) begin
            n_err++;
            $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                     e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
        end
        write0 = 1'b1; srcreg0 = 4'd2; srcval0 = retval;
        @(negedge clk);
        drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd2, 4'd2, PASS);
        #1;
        e = sb.pop_front();
        n_chk++;
        if ({dstval0, dstval1, retval, carry} !== e.v) begin
            n_err++;
            $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                     e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_pc_and_collision;
        exp_t       e;
        logic [3:0] ra [3];
        logic [3:0] rb [3];
        drive(1'b1, 4'd14, 8'h08, 1'b1, 4'd15, 8'h00, 4'd0, 4'd0, ADD);
        @(negedge clk);
        drive(1'b1, 4'd4, 8'hAA, 1'b1, 4'd4, 8'h55, 4'd0, 4'd0, ADD);
        @(negedge clk);
        drive(1'b0, 4'd4, 8'hC3, 1'b0, 4'd4, 8'h3C, 4'd0, 4'd0, ADD);
        @(negedge clk);
        ra = '{4'd14, 4'd4, 4'd4};
        rb = '{4'd15, 4'd4, 4'd14};
        push_exp("pc_pair_r14_r15", 8'h08, 8'h00, 8'h08, 1'b0);
        push_exp("collision_r4", 8'h55, 8'h55, 8'hAA, 1'b0);
        push_exp("no_write_r4_r14", 8'h55, 8'h08, 8'h5D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, ra[i], rb[i], ADD);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dstval0, dstval1, retval, carry} !== e.v) begin
                n_err++;
                $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                         e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu;
        exp_t       e;
        logic [3:0] ra [11];
        logic [3:0] rb [11];
        logic [2:0] op [11];
        drive(1'b1, 4'd6, 8'hFF, 1'b1, 4'd7, 8'h01, 4'd0, 4'd0, ADD);
        @(negedge clk);
        drive(1'b1, 4'd8, 8'h01, 1'b1, 4'd9, 8'h02, 4'd0, 4'd0, ADD);
        @(negedge clk);
        drive(1'b1, 4'd10, 8'hF0, 1'b1, 4'd11, 8'h3C, 4'd0, 4'd0, ADD);
        @(negedge clk);
        ra = '{4'd6, 4'd6, 4'd8, 4'd8, 4'd8, 4'd7, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10};
        rb = '{4'd7, 4'd7, 4'd9, 4'd9, 4'd9, 4'd8, 4'd8, 4'd11, 4'd11, 4'd11, 4'd11};
        op = '{ADD, SUB, SUB, LT, EQ, EQ, LT, AND_, OR_, NOT_, PASS};
        push_exp("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        push_exp("sub_ff_01", 8'hFF, 8'h01, 8'hFE, 1'b0);
        push_exp("sub_01_02", 8'h01, 8'h02, 8'hFF, 1'b1);
        push_exp("lt_01_02", 8'h01, 8'h02, 8'h01, 1'b0);
        push_exp("eq_01_02", 8'h01, 8'h02, 8'h00, 1'b0);
        push_exp("eq_01_01", 8'h01, 8'h01, 8'h01, 1'b0);
        push_exp("lt_02_01", 8'h02, 8'h01, 8'h00, 1'b0);
        push_exp("and_f0_3c", 8'hF0, 8'h3C, 8'h30, 1'b0);
        push_exp("or_f0_3c", 8'hF0, 8'h3C, 8'hFC, 1'b0);
        push_exp("not_f0", 8'hF0, 8'h3C, 8'h0F, 1'b0);
        push_exp("pass_f0", 8'hF0, 8'h3C, 8'hF0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, ra[i], rb[i], op[i]);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dstval0, dstval1, retval, carry} !== e.v) begin
                n_err++;
                $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                         e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bypass_and_reset;
        exp_t e;
        push_exp("same_cycle_r5", BYP ? 8'h77 : 8'h00, BYP ? 8'h77 : 8'h00, BYP ? 8'h77 : 8'h00, 1'b0);
        push_exp("after_edge_r5", 8'h77, 8'h77, 8'h77, 1'b0);
        push_exp("same_cycle_r12_pri", BYP ? 8'h22 : 8'h00, 8'h77, BYP ? 8'h22 : 8'h00, 1'b0);
        push_exp("after_edge_r12", 8'h22, 8'h77, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 4'd5, 8'h77, 1'b0, 4'd0, 8'h00, 4'd5, 4'd5, PASS);
                1:       drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd5, 4'd5, PASS);
                2:       drive(1'b1, 4'd12, 8'h11, 1'b1, 4'd12, 8'h22, 4'd12, 4'd5, PASS);
                default: drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd12, 4'd5, PASS);
            endcase
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dstval0, dstval1, retval, carry} !== e.v) begin
                n_err++;
                $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                         e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
            end
            @(negedge clk);
        end
        push_exp("async_reset_r5", 8'h00, 8'h00, 8'h00, 1'b0);
        push_exp("reset_mid_write_r5", 8'h00, 8'h00, 8'h00, 1'b0);
        push_exp("post_reset_r5", 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd5, 4'd5, ADD);
                    #2 rst_n = 1'b0;
                end
                1: drive(1'b1, 4'd5, 8'h33, 1'b1, 4'd5, 8'h44, 4'd5, 4'd5, ADD);
                default: drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd5, 4'd5, ADD);
            endcase
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({dstval0, dstval1, retval, carry} !== e.v) begin
                n_err++;
                $display("FAIL %s: got d0=%h d1=%h ret=%h c=%b, want d0=%h d1=%h ret=%h c=%b",
                         e.name, dstval0, dstval1, retval, carry, e.v[24:17], e.v[16:9], e.v[8:1], e.v[0]);
            end
            @(negedge clk);
            if (i == 1) begin
                drive(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd5, 4'd5, ADD);
                rst_n = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_add();
        test_pc_and_collision();
        test_alu();
        test_bypass_and_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
